// File: rtl/spi_slave_if.sv
// SPI slave bus bundle: serial pins, configuration, and the symbol-level
// data/status side seen by the local logic.
interface spi_slave_if #(
    parameter int DATA_BUS_WIDTH = 32
);
    logic                      sclk;
    logic                      scs;
    logic                      sin;
    logic                      sout;
    logic [1:0]                mode;
    logic                      bit_order;
    logic [5:0]                sym_size;
    logic [DATA_BUS_WIDTH-1:0] dout;
    logic [DATA_BUS_WIDTH-1:0] din;
    logic                      next;
    logic [15:0]               sym_cnt;
    logic                      busy;
    logic                      abort;

    modport slave (
        input  sclk, scs, sin, mode, bit_order, sym_size, dout,
        output sout, din, next, sym_cnt, busy, abort
    );

    modport master (
        output sclk, scs, sin, mode, bit_order, sym_size, dout,
        input  sout, din, next, sym_cnt, busy, abort
    );
endinterface

// File: rtl/spi_slave.sv
// SPI slave, all four modes, MSB/LSB first, 1..32-bit symbols. The SPI pins
// are oversampled in the clk domain through 2-flop synchronizers.
module spi_slave #(
    parameter int DATA_BUS_WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    spi_slave_if.slave bus
);
    localparam int W = DATA_BUS_WIDTH;

    typedef enum logic [1:0] {IDLE, ACTIVE, WAIT_RELEASE} state_t;

    state_t         state_q, state_d;
    logic [2:0]     sclk_sync_q, sclk_sync_d;
    logic [2:0]     scs_sync_q, scs_sync_d;
    logic [1:0]     sin_sync_q, sin_sync_d;
    logic [1:0]     rst_flush_q, rst_flush_d;
    logic [1:0]     mode_q, mode_d;
    logic           lsb_q, lsb_d;
    logic [5:0]     size_q, size_d;
    logic [5:0]     bit_cnt_q, bit_cnt_d;
    logic [W-1:0]   tx_q, tx_d;
    logic [W-1:0]   rx_q, rx_d;
    logic [W-1:0]   din_q, din_d;
    logic [15:0]    sym_cnt_q, sym_cnt_d;
    logic           next_q, next_d;
    logic           abort_q, abort_d;
    logic           busy_q, busy_d;
    logic           sout_q, sout_d;
    logic           reload_q, reload_d;

    logic sclk_rise, sclk_fall, scs_rise, scs_fall, sin_s;
    logic lead_edge, trail_edge, sample_edge, shift_edge;
    logic [5:0] cfg_size, cfg_shamt, shamt;

    // Edges are taken between the synchronized stage and one stage later;
    // sin is read from the same synchronized stage so it lines up with sclk.
    assign sclk_rise   = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign sclk_fall   = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign scs_rise    = scs_sync_q[1] & ~scs_sync_q[2];
    assign scs_fall    = ~scs_sync_q[1] & scs_sync_q[2];
    assign sin_s       = sin_sync_q[1];
    assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
    assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
    assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
    assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;

    assign cfg_size  = ((bus.sym_size == 6'd0) || (bus.sym_size > 6'd32)) ? 6'd32 : bus.sym_size;
    assign cfg_shamt = 6'd32 - cfg_size;
    assign shamt     = 6'd32 - size_q;

    // MSB-first symbols are left-justified so the head bit is always the top bit.
    function automatic logic [W-1:0] align_tx(input logic [W-1:0] d, input logic lsb, input logic [5:0] sh);
        return lsb ? d : (d << sh);
    endfunction

    function automatic logic tx_head(input logic [W-1:0] t, input logic lsb);
        return lsb ? t[0] : t[W-1];
    endfunction

    function automatic logic [W-1:0] tx_shift(input logic [W-1:0] t, input logic lsb);
        return lsb ? (t >> 1) : (t << 1);
    endfunction

    // Next-state logic for synchronizers, transaction FSM and datapath.
    always_comb begin
        logic [W-1:0] tx_init;
        logic [W-1:0] tx_src;
        logic [W-1:0] rx_next;

        sclk_sync_d = {sclk_sync_q[1:0], bus.sclk};
        scs_sync_d  = {scs_sync_q[1:0], bus.scs};
        sin_sync_d  = {sin_sync_q[0], bus.sin};
        state_d     = state_q;
        rst_flush_d = rst_flush_q;
        mode_d      = mode_q;
        lsb_d       = lsb_q;
        size_d      = size_q;
        bit_cnt_d   = bit_cnt_q;
        tx_d        = tx_q;
        rx_d        = rx_q;
        din_d       = din_q;
        sym_cnt_d   = sym_cnt_q;
        next_d      = 1'b0;
        abort_d     = 1'b0;
        busy_d      = busy_q;
        sout_d      = sout_q;
        reload_d    = next_q;
        tx_init     = align_tx(bus.dout, bus.bit_order, cfg_shamt);
        tx_src      = reload_q ? align_tx(bus.dout, lsb_q, shamt) : tx_q;
        rx_next     = lsb_q ? {sin_s, rx_q[W-1:1]} : {rx_q[W-2:0], sin_s};

        unique case (state_q)
            IDLE: begin
                sout_d = 1'b0;
                // Right after reset the scs synchronizer still holds its idle
                // value; wait for it to flush so a held-low scs is not taken
                // as a fresh falling edge.
                if (rst_flush_q != 2'd0) begin
                    rst_flush_d = rst_flush_q - 2'd1;
                    if (!scs_sync_q[1]) begin
                        rst_flush_d = 2'd0;
                        state_d     = WAIT_RELEASE;
                    end
                end else if (scs_fall) begin
                    state_d   = ACTIVE;
                    mode_d    = bus.mode;
                    lsb_d     = bus.bit_order;
                    size_d    = cfg_size;
                    bit_cnt_d = '0;
                    sym_cnt_d = '0;
                    busy_d    = 1'b1;
                    if (!bus.mode[0]) begin
                        sout_d = tx_head(tx_init, bus.bit_order);
                        tx_d   = tx_shift(tx_init, bus.bit_order);
                    end else begin
                        tx_d   = tx_init;
                    end
                end
            end
            ACTIVE: begin
                if (scs_rise) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    sout_d  = 1'b0;
                    abort_d = (bit_cnt_q != 6'd0);
                end else begin
                    tx_d = tx_src;
                    if (shift_edge) begin
                        sout_d = tx_head(tx_src, lsb_q);
                        tx_d   = tx_shift(tx_src, lsb_q);
                    end
                    if (sample_edge) begin
                        rx_d = rx_next;
                        if (bit_cnt_q == size_q - 6'd1) begin
                            bit_cnt_d = '0;
                            next_d    = 1'b1;
                            din_d     = lsb_q ? (rx_next >> shamt) : (rx_next & ({W{1'b1}} >> shamt));
                            if (sym_cnt_q != 16'hFFFF) begin
                                sym_cnt_d = sym_cnt_q + 16'd1;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 6'd1;
                        end
                    end
                end
            end
            WAIT_RELEASE: begin
                sout_d = 1'b0;
                if (scs_sync_q[1]) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sclk_sync_q <= '0;
            scs_sync_q  <= '1;
            sin_sync_q  <= '0;
            rst_flush_q <= 2'd3;
            mode_q      <= '0;
            lsb_q       <= 1'b0;
            size_q      <= 6'd32;
            bit_cnt_q   <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            din_q       <= '0;
            sym_cnt_q   <= '0;
            next_q      <= 1'b0;
            abort_q     <= 1'b0;
            busy_q      <= 1'b0;
            sout_q      <= 1'b0;
            reload_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_sync_q <= sclk_sync_d;
            scs_sync_q  <= scs_sync_d;
            sin_sync_q  <= sin_sync_d;
            rst_flush_q <= rst_flush_d;
            mode_q      <= mode_d;
            lsb_q       <= lsb_d;
            size_q      <= size_d;
            bit_cnt_q   <= bit_cnt_d;
            tx_q        <= tx_d;
            rx_q        <= rx_d;
            din_q       <= din_d;
            sym_cnt_q   <= sym_cnt_d;
            next_q      <= next_d;
            abort_q     <= abort_d;
            busy_q      <= busy_d;
            sout_q      <= sout_d;
            reload_q    <= reload_d;
        end
    end

    assign bus.sout    = sout_q;
    assign bus.din     = din_q;
    assign bus.next    = next_q;
    assign bus.sym_cnt = sym_cnt_q;
    assign bus.busy    = busy_q;
    assign bus.abort   = abort_q;
endmodule

// File: tb/tb_spi_slave.sv
// Scoreboard bench for spi_slave: a bit-banged SPI master drives the pins,
// expected din/sym_cnt per symbol are queued and checked on each next pulse.
`timescale 1ns/1ps
module tb_spi_slave;
    logic clk;
    logic rst;

    spi_slave_if #(.DATA_BUS_WIDTH(32)) bus();

    spi_slave #(.DATA_BUS_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic [31:0] din;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          next_cnt = 0;
    int          abort_cnt = 0;
    int          next_ref = 0;
    logic        dout_inc = 1'b0;
    logic [31:0] dout_base = '0;
    logic        cpol, cpha, lsb;
    int          half = 10;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source model: dout advances by one for every next pulse when enabled.
    assign bus.dout = dout_base + (dout_inc ? 32'(next_cnt - next_ref) : 32'd0);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per next pulse.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.next === 1'b1) begin
                next_cnt++;
                if (sb_q.size() == 0) begin
                    chk("next_without_expect", 32'(sb_q.size()), 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    chk("din", bus.din, e.din);
                    chk("sym_cnt_at_next", 32'(bus.sym_cnt), 32'(e.cnt));
                end
            end
            if (bus.abort === 1'b1) begin
                abort_cnt++;
                chk("next_abort_exclusive", 32'(bus.next), 32'd0);
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg(input logic [1:0] m, input logic order, input logic [5:0] size, input int h);
        bus.mode      = m;
        bus.bit_order = order;
        bus.sym_size  = size;
        cpol = m[1];
        cpha = m[0];
        lsb  = order;
        half = h;
    endtask

    // Drops scs and returns 3 clk later; caller waits the rest of the half period.
    task automatic start_txn();
        bus.sclk = cpol;
        wait_clk(4);
        bus.scs = 1'b0;
        wait_clk(3);
    endtask

    task automatic end_txn();
        wait_clk(half);
        bus.scs = 1'b1;
        wait_clk(6);
    endtask

    // Shifts nbits of one size-bit symbol; miso is reassembled by bit index.
    task automatic spi_bits(input logic [31:0] mosi, input int size, input int nbits, output logic [31:0] miso);
        int idx;
        miso = '0;
        for (int k = 0; k < nbits; k++) begin
            idx = lsb ? k : (size - 1 - k);
            if (!cpha) begin
                bus.sin = mosi[idx];
                wait_clk(half);
                miso[idx] = bus.sout;
                bus.sclk = ~cpol;
                wait_clk(half);
                bus.sclk = cpol;
            end else begin
                bus.sclk = ~cpol;
                bus.sin  = mosi[idx];
                wait_clk(half);
                miso[idx] = bus.sout;
                bus.sclk = cpol;
                wait_clk(half);
            end
        end
    endtask

    initial begin
        logic [31:0] miso;
        logic [7:0]  m_tx, s_tx;
        int          nref, aref;

        rst = 1'b1;
        bus.scs = 1'b1;
        bus.sclk = 1'b0;
        bus.sin = 1'b0;
        cfg(2'd0, 1'b0, 6'd8, 10);
        wait_clk(5);
        chk("rst_sout", 32'(bus.sout), 32'd0);
        chk("rst_din", bus.din, 32'd0);
        chk("rst_next", 32'(bus.next), 32'd0);
        chk("rst_sym_cnt", 32'(bus.sym_cnt), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_abort", 32'(bus.abort), 32'd0);
        rst = 1'b0;
        wait_clk(5);

        // Mode 0, MSB first, 8 bits, sclk = clk/20.
        dout_base = 32'h0000_00AA;
        nref = next_cnt;
        sb_q.push_back(exp_t'{din: 32'h55, cnt: 16'd1});
        start_txn();
        chk("first_bit_3clk", 32'(bus.sout), 32'd1);
        chk("busy_active", 32'(bus.busy), 32'd1);
        wait_clk(half - 3);
        spi_bits(32'h55, 8, 8, miso);
        chk("miso_mode0", miso, 32'hAA);
        end_txn();
        chk("sym_cnt_hold", 32'(bus.sym_cnt), 32'd1);
        chk("next_pulses_1", 32'(next_cnt - nref), 32'd1);
        chk("busy_idle", 32'(bus.busy), 32'd0);
        chk("sout_idle", 32'(bus.sout), 32'd0);

        // Modes 1..3: back-to-back streams, dout counts up, master data counts down.
        for (int m = 1; m <= 3; m++) begin
            cfg(2'(m), 1'b0, 6'd8, 5);
            dout_base = 32'h0000_00AA;
            next_ref  = next_cnt;
            dout_inc  = 1'b1;
            start_txn();
            wait_clk(half - 3);
            m_tx = 8'h55;
            s_tx = 8'hAA;
            for (int k = 0; k < 100; k++) begin
                sb_q.push_back(exp_t'{din: 32'(m_tx), cnt: 16'(k + 1)});
                spi_bits(32'(m_tx), 8, 8, miso);
                chk($sformatf("miso_mode%0d_sym%0d", m, k), miso, 32'(s_tx));
                m_tx = m_tx - 8'd1;
                s_tx = s_tx + 8'd1;
            end
            end_txn();
            dout_inc = 1'b0;
            chk($sformatf("sym_cnt_mode%0d", m), 32'(bus.sym_cnt), 32'd100);
        end

        // LSB first, 32 bits (sym_size 0 means 32), then 16 bits with stale upper dout bits.
        cfg(2'd0, 1'b1, 6'd0, 5);
        dout_base = 32'hAAAA_AAAA;
        sb_q.push_back(exp_t'{din: 32'h5555_5555, cnt: 16'd1});
        start_txn();
        wait_clk(half - 3);
        spi_bits(32'h5555_5555, 32, 32, miso);
        chk("miso_lsb32", miso, 32'hAAAA_AAAA);
        end_txn();

        cfg(2'd0, 1'b1, 6'd16, 5);
        dout_base = 32'h1234_AAAA;
        sb_q.push_back(exp_t'{din: 32'h0000_5555, cnt: 16'd1});
        start_txn();
        wait_clk(half - 3);
        spi_bits(32'h0000_5555, 16, 16, miso);
        chk("miso_lsb16", miso, 32'h0000_AAAA);
        end_txn();

        // Abort after 5 of 8 bits.
        cfg(2'd0, 1'b0, 6'd8, 5);
        dout_base = 32'h0000_00C3;
        nref = next_cnt;
        aref = abort_cnt;
        start_txn();
        wait_clk(half - 3);
        spi_bits(32'hFF, 8, 5, miso);
        chk("miso_partial", miso, 32'hC0);
        wait_clk(half);
        bus.scs = 1'b1;
        wait_clk(3);
        chk("abort_sout_3clk", 32'(bus.sout), 32'd0);
        chk("abort_busy", 32'(bus.busy), 32'd0);
        wait_clk(5);
        chk("abort_pulses", 32'(abort_cnt - aref), 32'd1);
        chk("abort_no_next", 32'(next_cnt - nref), 32'd0);
        chk("abort_din_kept", bus.din, 32'h0000_5555);
        chk("abort_sym_cnt", 32'(bus.sym_cnt), 32'd0);

        // Reset mid-symbol with scs held low; no restart until scs toggles.
        dout_base = 32'h0000_000F;
        nref = next_cnt;
        aref = abort_cnt;
        start_txn();
        wait_clk(half - 3);
        spi_bits(32'hFF, 8, 3, miso);
        rst = 1'b1;
        wait_clk(3);
        chk("mid_rst_sout", 32'(bus.sout), 32'd0);
        chk("mid_rst_din", bus.din, 32'd0);
        chk("mid_rst_next", 32'(bus.next), 32'd0);
        chk("mid_rst_sym_cnt", 32'(bus.sym_cnt), 32'd0);
        chk("mid_rst_busy", 32'(bus.busy), 32'd0);
        chk("mid_rst_abort", 32'(bus.abort), 32'd0);
        rst = 1'b0;
        wait_clk(4);
        spi_bits(32'hFF, 8, 8, miso);
        wait_clk(4);
        chk("held_low_busy", 32'(bus.busy), 32'd0);
        chk("held_low_sout", 32'(bus.sout), 32'd0);
        chk("held_low_no_next", 32'(next_cnt - nref), 32'd0);
        chk("held_low_no_abort", 32'(abort_cnt - aref), 32'd0);
        bus.scs = 1'b1;
        wait_clk(6);

        dout_base = 32'h0000_0055;
        sb_q.push_back(exp_t'{din: 32'hAA, cnt: 16'd1});
        start_txn();
        wait_clk(half - 3);
        spi_bits(32'hAA, 8, 8, miso);
        chk("miso_after_rst", miso, 32'h55);
        end_txn();
        chk("sym_cnt_after_rst", 32'(bus.sym_cnt), 32'd1);

        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
